// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered 2-to-4 decoder with hold timer.
// Holds the FSM state encoding, the code/output widths and the one-hot decode function.
package decoder_pkg;

  localparam int CODE_W = 2;
  localparam int OUT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bit i of the result corresponds to code i. An unknown code yields all-zero,
  // which keeps the one-hot guarantee even if a bad code slips through.
  function automatic logic [OUT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] word;
    word = '0;
    case (code)
      2'd0:    word = 4'b0001;
      2'd1:    word = 4'b0010;
      2'd2:    word = 4'b0100;
      2'd3:    word = 4'b1000;
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with a zero flag; load takes priority over decrement.
// Used by decoder2_4_hold to time how long a decoded word stays asserted.
module hold_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/decoder2_4_hold.sv
// Registered 2-to-4 decoder: a valid code produces a one-hot word held for
// HOLD_CYCLES cycles, retriggerable, with a one-cycle done pulse on expiry.
module decoder2_4_hold
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              decoder_valid,
  input  logic [CODE_W-1:0] decoder_in,
  output logic [OUT_W-1:0]  decoder_out,
  output logic              decoder_busy,
  output logic              decoder_done
);

  localparam int             CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               done_q, done_d;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]   cnt_value;

  hold_counter #(.W(CNT_W)) u_hold_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = '0;
        if (decoder_valid) begin
          out_d    = decode_onehot(decoder_in);
          cnt_load = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // decoder_in is only looked at under decoder_valid, so X/Z on an idle
        // bus never reaches out_q.
        if (decoder_valid) begin
          out_d    = decode_onehot(decoder_in);
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          out_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        out_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign decoder_out  = out_q;
  assign decoder_busy = (state_q == HOLD);
  assign decoder_done = done_q;

endmodule

// File: tb/tb_decoder2_4_hold.sv
// Directed self-checking bench for decoder2_4_hold: a HOLD_CYCLES=4 instance and
// a HOLD_CYCLES=1 instance, expected values hand-computed per vector.
module tb_decoder2_4_hold;

  logic       clk;
  logic       rst_n;
  logic       valid4, valid1;
  logic [1:0] in4, in1;
  logic [3:0] out4, out1;
  logic       busy4, busy1, done4, done1;

  int n_compared   = 0;
  int n_mismatched = 0;
  int done_pulses  = 0;

  decoder2_4_hold #(.HOLD_CYCLES(4)) dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .decoder_valid (valid4),
    .decoder_in    (in4),
    .decoder_out   (out4),
    .decoder_busy  (busy4),
    .decoder_done  (done4)
  );

  decoder2_4_hold #(.HOLD_CYCLES(1)) dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .decoder_valid (valid1),
    .decoder_in    (in1),
    .decoder_out   (out1),
    .decoder_busy  (busy1),
    .decoder_done  (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {busy, done, out}.
  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got busy/done/out=%b required %b", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] exp_w(input logic b, input logic d, input logic [3:0] o);
    return {b, d, o};
  endfunction

  function automatic logic [3:0] oh(input int c);
    logic [3:0] w;
    w = 4'b0001 << c;
    return w;
  endfunction

  initial begin
    rst_n  = 1'b0;
    valid4 = 1'b0; in4 = 2'd0;
    valid1 = 1'b0; in1 = 2'd0;
    #12;
    check("reset_dut4", {busy4, done4, out4}, 6'b0);
    check("reset_dut1", {busy1, done1, out1}, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single valid of code 2: held for 4 cycles, then done.
    valid4 = 1'b1; in4 = 2'd2;
    step();
    check("single_load", {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b0100));
    valid4 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("single_hold%0d", k), {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b0100));
    end
    step();
    check("single_done", {busy4, done4, out4}, exp_w(1'b0, 1'b1, 4'b0000));
    step();
    check("single_idle", {busy4, done4, out4}, exp_w(1'b0, 1'b0, 4'b0000));

    // Sweep all codes, each followed by 6 idle cycles.
    done_pulses = 0;
    for (int c = 0; c < 4; c++) begin
      valid4 = 1'b1; in4 = 2'(c);
      step();
      check($sformatf("sweep%0d_load", c), {busy4, done4, out4}, exp_w(1'b1, 1'b0, oh(c)));
      valid4 = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (done4) done_pulses++;
        if (i < 3)
          check($sformatf("sweep%0d_c%0d", c, i), {busy4, done4, out4}, exp_w(1'b1, 1'b0, oh(c)));
        else if (i == 3)
          check($sformatf("sweep%0d_done", c), {busy4, done4, out4}, exp_w(1'b0, 1'b1, 4'b0000));
        else
          check($sformatf("sweep%0d_idle%0d", c, i), {busy4, done4, out4}, exp_w(1'b0, 1'b0, 4'b0000));
      end
    end
    check("sweep_done_count", 6'(done_pulses), 6'd4);

    // Code 1 then code 3 two cycles later.
    valid4 = 1'b1; in4 = 2'd1;
    step();
    check("retrig_a0", {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b0010));
    valid4 = 1'b0;
    step();
    check("retrig_a1", {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b0010));
    valid4 = 1'b1; in4 = 2'd3;
    step();
    check("retrig_b0", {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b1000));
    valid4 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("retrig_b%0d", k), {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b1000));
    end
    step();
    check("retrig_done", {busy4, done4, out4}, exp_w(1'b0, 1'b1, 4'b0000));
    step();

    // Same-code retrigger in the final hold cycle restarts the full hold.
    valid4 = 1'b1; in4 = 2'd0;
    step();
    valid4 = 1'b0;
    for (int k = 1; k < 4; k++) step();
    check("last_cycle_pre", {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b0001));
    valid4 = 1'b1; in4 = 2'd0;
    step();
    check("last_cycle_retrig", {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b0001));
    valid4 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("last_cycle_hold%0d", k), {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b0001));
    end
    step();
    check("last_cycle_done", {busy4, done4, out4}, exp_w(1'b0, 1'b1, 4'b0000));
    step();

    // Asynchronous reset mid-hold, then X on the idle input bus.
    valid4 = 1'b1; in4 = 2'd3;
    step();
    valid4 = 1'b0;
    step();
    check("abort_pre", {busy4, done4, out4}, exp_w(1'b1, 1'b0, 4'b1000));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", {busy4, done4, out4}, exp_w(1'b0, 1'b0, 4'b0000));
    in4 = 2'bxx;
    step();
    check("abort_in_reset", {busy4, done4, out4}, exp_w(1'b0, 1'b0, 4'b0000));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("x_idle%0d", k), {busy4, done4, out4}, exp_w(1'b0, 1'b0, 4'b0000));
    end
    in4 = 2'd0;

    // HOLD_CYCLES=1: back-to-back valids, new word every cycle, one done at end.
    for (int c = 0; c < 4; c++) begin
      valid1 = 1'b1; in1 = 2'(c);
      step();
      check($sformatf("h1_word%0d", c), {busy1, done1, out1}, exp_w(1'b1, 1'b0, oh(c)));
    end
    valid1 = 1'b0;
    step();
    check("h1_done", {busy1, done1, out1}, exp_w(1'b0, 1'b1, 4'b0000));
    step();
    check("h1_idle", {busy1, done1, out1}, exp_w(1'b0, 1'b0, 4'b0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
